// File: rtl/lau_pkg.sv
// Shared types for the arithmetic library: prefix-structure speed selector
// and counter mode, plus a helper for sizing prefix trees.
package lau_pkg;

  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

  typedef enum logic {
    ONESHOT = 1'b0,
    RELOAD  = 1'b1
  } cnt_mode_e;

  // Number of doubling levels needed for a log-depth prefix tree over n bits.
  function automatic int unsigned prefix_levels(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/DecC.sv
// Prefix-logic decrementer with carry-in: Z = A - CI, CO = borrow out of the MSB.
// speed selects a serial (SLOW) or log-depth doubling (FAST) zero-prefix tree.
module DecC
  import lau_pkg::*;
#(
  parameter int unsigned width = 16,
  parameter speed_e      speed = FAST
) (
  input  logic [width-1:0] A,
  input  logic             CI,
  output logic [width-1:0] Z,
  output logic             CO
);

  localparam int unsigned    levels = prefix_levels(width);
  localparam logic [width-1:0] ones = '1;

  // zpre[i] is set when A[i:0] is all zero, i.e. a borrow ripples past bit i.
  logic [width-1:0] zpre;

  always_comb begin
    zpre = ~A;
    if (speed == FAST) begin
      for (int unsigned k = 0; k < levels; k++) begin
        zpre = zpre & ((zpre << (1 << k)) | ~(ones << (1 << k)));
      end
    end else begin
      for (int unsigned i = 1; i < width; i++) begin
        zpre[i] = zpre[i] & zpre[i-1];
      end
    end
  end

  assign Z  = A ^ ({zpre[width-2:0], 1'b1} & {width{CI}});
  assign CO = CI & zpre[width-1];

endmodule

// File: rtl/dec_counter_bank.sv
// Bank of independent loadable down-counters with one-shot or auto-reload mode,
// a registered one-cycle terminal-count pulse and a running flag per channel.
module dec_counter_bank
  import lau_pkg::*;
#(
  parameter int unsigned channels = 4,
  parameter int unsigned width    = 16,
  parameter speed_e      speed    = FAST
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [channels-1:0]         LD,
  input  logic [channels*width-1:0]   LDVAL,
  input  logic [channels-1:0]         MODE,
  input  logic [channels-1:0]         EN,
  output logic [channels*width-1:0]   CNT,
  output logic [channels-1:0]         TC,
  output logic [channels-1:0]         ACT
);

  localparam logic [width-1:0] one = width'(1);

  for (genvar i = 0; i < channels; i++) begin : g_ch
    logic [width-1:0] cnt_q;
    logic [width-1:0] rld_q;
    logic [width-1:0] dec;
    logic [width-1:0] ldval;
    logic             act_q;
    logic             tc_q;
    logic             co;
    logic             terminal;
    cnt_mode_e        mode;

    assign ldval    = LDVAL[i*width +: width];
    assign mode     = cnt_mode_e'(MODE[i]);
    assign terminal = (cnt_q == one);

    DecC #(
      .width (width),
      .speed (speed)
    ) u_dec (
      .A  (cnt_q),
      .CI (1'b1),
      .Z  (dec),
      .CO (co)
    );

    // ACT gates counting so an idle channel parks at zero instead of wrapping.
    always_ff @(posedge CLK) begin
      if (RST) begin
        cnt_q <= '0;
        rld_q <= '0;
        act_q <= 1'b0;
        tc_q  <= 1'b0;
      end else if (LD[i]) begin
        cnt_q <= ldval;
        rld_q <= ldval;
        act_q <= (ldval != '0);
        tc_q  <= 1'b0;
      end else if (act_q && EN[i]) begin
        if (terminal) begin
          tc_q <= 1'b1;
          if (mode == RELOAD) begin
            cnt_q <= rld_q;
          end else begin
            cnt_q <= '0;
            act_q <= 1'b0;
          end
        end else begin
          cnt_q <= dec;
          tc_q  <= 1'b0;
        end
      end else begin
        tc_q <= 1'b0;
      end
    end

    assert property (@(posedge CLK) disable iff (RST) act_q |-> !co);

    assign CNT[i*width +: width] = cnt_q;
    assign TC[i]                 = tc_q;
    assign ACT[i]                = act_q;
  end

endmodule

// File: tb/tb_dec_counter_bank.sv
// Scoreboarded random/directed bench for dec_counter_bank against an integer reference model.
module tb_dec_counter_bank;
  import lau_pkg::*;

  localparam int CH = 4;
  localparam int W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     ld;
  logic [CH*W-1:0]   ldval;
  logic [CH-1:0]     mode;
  logic [CH-1:0]     en;
  logic [CH*W-1:0]   cnt;
  logic [CH-1:0]     tc;
  logic [CH-1:0]     act;

  dec_counter_bank #(
    .channels (CH),
    .width    (W),
    .speed    (FAST)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .LD    (ld),
    .LDVAL (ldval),
    .MODE  (mode),
    .EN    (en),
    .CNT   (cnt),
    .TC    (tc),
    .ACT   (act)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   tc;
    logic [CH-1:0]   act;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model state: plain integers per channel.
  longint m_cnt[CH];
  longint m_rld[CH];
  bit     m_act[CH];
  bit     m_tc[CH];

  function automatic logic [CH*W-1:0] put(input logic [CH*W-1:0] vec, input int ch,
                                          input logic [W-1:0] val);
    logic [CH*W-1:0] r;
    r = vec;
    r[ch*W +: W] = val;
    return r;
  endfunction

  task automatic step(input logic r, input logic [CH-1:0] l, input logic [CH*W-1:0] v,
                      input logic [CH-1:0] m, input logic [CH-1:0] e);
    exp_t x;
    @(negedge clk);
    rst = r; ld = l; ldval = v; mode = m; en = e;
    cycle++;
    for (int c = 0; c < CH; c++) begin
      longint lv;
      lv = longint'(v[c*W +: W]);
      if (r) begin
        m_cnt[c] = 0; m_rld[c] = 0; m_act[c] = 0; m_tc[c] = 0;
      end else if (l[c]) begin
        m_cnt[c] = lv; m_rld[c] = lv; m_act[c] = (lv != 0); m_tc[c] = 0;
      end else if (m_act[c] && e[c]) begin
        if (m_cnt[c] == 1) begin
          m_tc[c] = 1;
          if (m[c]) m_cnt[c] = m_rld[c];
          else begin m_cnt[c] = 0; m_act[c] = 0; end
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
          m_tc[c]  = 0;
        end
      end else begin
        m_tc[c] = 0;
      end
      x.cnt[c*W +: W] = W'(m_cnt[c]);
      x.tc[c]  = m_tc[c];
      x.act[c] = m_act[c];
    end
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per clock once stimulus has started.
  initial begin
    exp_t x;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty at %0t: got no expected entry, required one per cycle", $time);
      end else begin
        x = exp_q.pop_front();
        for (int c = 0; c < CH; c++) begin
          checks++;
          if (cnt[c*W +: W] !== x.cnt[c*W +: W]) begin
            errors++;
            $display("FAIL cnt[%0d] at %0t: got %0d required %0d", c, $time,
                     cnt[c*W +: W], x.cnt[c*W +: W]);
          end
        end
        checks++;
        if (tc !== x.tc) begin
          errors++;
          $display("FAIL tc at %0t: got %b required %b", $time, tc, x.tc);
        end
        checks++;
        if (act !== x.act) begin
          errors++;
          $display("FAIL act at %0t: got %b required %b", $time, act, x.act);
        end
      end
    end
  end

  initial begin
    logic [CH*W-1:0] v;
    rst = 1'b1; ld = '0; ldval = '0; mode = '0; en = '0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_rld[c] = 0; m_act[c] = 0; m_tc[c] = 0;
    end

    // Reset with loads and enables toggling underneath.
    step(1'b1, 4'b1111, {4{16'd7}}, 4'b0101, 4'b1111);
    step(1'b1, 4'b1010, {4{16'd3}}, 4'b1010, 4'b0101);

    // One-shot on ch0 from 3.
    step(1'b0, 4'b0001, put('0, 0, 16'd3), 4'b0000, 4'b0001);
    repeat (6) step(1'b0, 4'b0000, '0, 4'b0000, 4'b0001);

    // Auto-reload on ch1 with period 4.
    step(1'b0, 4'b0010, put('0, 1, 16'd4), 4'b0010, 4'b0010);
    repeat (12) step(1'b0, 4'b0000, '0, 4'b0010, 4'b0010);

    // Gating on ch2, zero load on ch3, reload-by-1 on ch0.
    v = put(put(put('0, 2, 16'd2), 3, 16'd0), 0, 16'd1);
    step(1'b0, 4'b1101, v, 4'b0011, 4'b0000);
    for (int k = 0; k < 8; k++)
      step(1'b0, 4'b0000, '0, 4'b0011, (k % 2 == 0) ? 4'b1101 : 4'b1001);

    // Load colliding with the terminal edge on ch1.
    step(1'b0, 4'b0010, put('0, 1, 16'd2), 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, '0, 4'b0000, 4'b0010);
    step(1'b0, 4'b0010, put('0, 1, 16'd9), 4'b0000, 4'b0010);
    repeat (2) step(1'b0, 4'b0000, '0, 4'b0000, 4'b0010);

    // Reset mid-count at 5 on ch2.
    step(1'b0, 4'b0100, put('0, 2, 16'd7), 4'b0000, 4'b0000);
    repeat (2) step(1'b0, 4'b0000, '0, 4'b0000, 4'b0100);
    step(1'b1, 4'b0000, '0, 4'b0000, 4'b0100);
    step(1'b0, 4'b0000, '0, 4'b0000, 4'b0100);

    // Full-scale load counts down without wrapping.
    step(1'b0, 4'b1000, put('0, 3, 16'hFFFF), 4'b0000, 4'b0000);
    repeat (20) step(1'b0, 4'b0000, '0, 4'b0000, 4'b1000);

    // Random traffic across all channels.
    for (int k = 0; k < 800; k++) begin
      logic [CH-1:0] l, m, e;
      logic          r;
      r = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < CH; c++) begin
        l[c] = ($urandom_range(0, 9) == 0);
        e[c] = ($urandom_range(0, 3) != 0);
        m[c] = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 15) == 0) v[c*W +: W] = W'($urandom());
        else v[c*W +: W] = W'($urandom_range(0, 12));
      end
      step(r, l, v, m, e);
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
